// File: rtl/hazard_scoreboard_pkg.sv
// Shared hazard encodings: Tuse/Tnew conventions used by the decoder and the
// forwarding select codes driven by the scoreboard.
package hazard_scoreboard_pkg;

   localparam logic [3:0] T_USE_AT_D       = 4'd0;
   localparam logic [3:0] T_USE_AT_E       = 4'd1;
   localparam logic [3:0] T_USE_AT_M       = 4'd2;
   localparam logic [3:0] T_USE_NEVER_READ = 4'hF;

   localparam logic [3:0] T_NEW_NO_NEW    = 4'd0;
   localparam logic [3:0] T_NEW_AT_ID_EX  = 4'd1;
   localparam logic [3:0] T_NEW_AT_EX_MEM = 4'd2;
   localparam logic [3:0] T_NEW_AT_MEM_WB = 4'd3;

   localparam int unsigned FWD_SEL_OWN    = 0;
   localparam int unsigned FWD_SEL_ID_EX  = 1;
   localparam int unsigned FWD_SEL_EX_MEM = 2;
   localparam int unsigned FWD_SEL_MEM_WB = 3;

endpackage

// File: rtl/hazard_scoreboard_md_busy.sv
// HI/LO busy tracker: a mult/div in E loads its latency, then the count
// drains to zero; busy while non-zero.
module hsb_md_busy #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   localparam int unsigned CW      = $clog2(DIV_LAT + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic is_div_i,
   output logic busy_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = is_div_i ? CW'(DIV_LAT) : CW'(MULT_LAT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard for the 5-stage pipeline: tracks in-flight
// producers after D, raises the D stall and picks forwarding sources.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 3,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned T_W        = 4,
   parameter int unsigned MULT_LAT   = 5,
   parameter int unsigned DIV_LAT    = 10,
   localparam int unsigned FW        = $clog2(NUM_STAGES + 1)
) (
   input  logic              HSB_i_Clk,
   input  logic              HSB_i_Reset,
   input  logic [REG_AW-1:0] HSB_i_RsD,
   input  logic [REG_AW-1:0] HSB_i_RtD,
   input  logic [T_W-1:0]    HSB_i_TuseRs,
   input  logic [T_W-1:0]    HSB_i_TuseRt,
   input  logic [T_W-1:0]    HSB_i_TnewD,
   input  logic [REG_AW-1:0] HSB_i_RegWAddrD,
   input  logic              HSB_i_MdStartD,
   input  logic              HSB_i_MdIsDivD,
   input  logic              HSB_i_MdUseD,
   output logic              HSB_o_Stall,
   output logic [FW-1:0]     HSB_o_FwdRsD,
   output logic [FW-1:0]     HSB_o_FwdRtD,
   output logic [FW-1:0]     HSB_o_FwdRsE,
   output logic [FW-1:0]     HSB_o_FwdRtE,
   output logic [FW-1:0]     HSB_o_FwdRtM,
   output logic              HSB_o_MdBusy
);

   localparam logic [T_W-1:0] TUSE_NEVER = T_W'(T_USE_NEVER_READ);
   localparam logic [T_W-1:0] TNEW_NONE  = T_W'(T_NEW_NO_NEW);
   localparam logic [FW-1:0]  FWD_OWN    = FW'(FWD_SEL_OWN);

   function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] t);
      return (t == '0) ? '0 : t - T_W'(1);
   endfunction

   function automatic logic slot_hit(input logic [REG_AW-1:0] addr,
                                     input logic [REG_AW-1:0] op);
      return (addr != '0) && (addr == op);
   endfunction

   logic [REG_AW-1:0] slot_addr_q [NUM_STAGES];
   logic [T_W-1:0]    slot_tnew_q [NUM_STAGES];
   logic [REG_AW-1:0] rs_e_q, rt_e_q, rt_m_q;
   logic              md_start_e_q, md_is_div_e_q;
   logic              md_busy;
   logic              stall, stall_rs, stall_rt, stall_md;
   logic              hit_rs_d, hit_rt_d, hit_rs_e, hit_rt_e, hit_rt_m;

   always_ff @(posedge HSB_i_Clk or posedge HSB_i_Reset) begin
      if (HSB_i_Reset) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            slot_addr_q[k] <= '0;
            slot_tnew_q[k] <= '0;
         end
         rs_e_q        <= '0;
         rt_e_q        <= '0;
         rt_m_q        <= '0;
         md_start_e_q  <= 1'b0;
         md_is_div_e_q <= 1'b0;
      end else begin
         for (int k = 1; k < NUM_STAGES; k++) begin
            slot_addr_q[k] <= slot_addr_q[k-1];
            slot_tnew_q[k] <= dec_sat(slot_tnew_q[k-1]);
         end
         if (stall) begin
            // Bubble into ID/EX: nothing produced, nothing consumed.
            slot_addr_q[0] <= '0;
            slot_tnew_q[0] <= '0;
            rs_e_q         <= '0;
            rt_e_q         <= '0;
            md_start_e_q   <= 1'b0;
            md_is_div_e_q  <= 1'b0;
         end else begin
            slot_addr_q[0] <= (HSB_i_TnewD == TNEW_NONE) ? '0 : HSB_i_RegWAddrD;
            slot_tnew_q[0] <= dec_sat(HSB_i_TnewD);
            rs_e_q         <= HSB_i_RsD;
            rt_e_q         <= HSB_i_RtD;
            md_start_e_q   <= HSB_i_MdStartD;
            md_is_div_e_q  <= HSB_i_MdIsDivD;
         end
         rt_m_q <= rt_e_q;
      end
   end

   // Lowest slot is scanned first; the hit flags shadow older producers.
   always_comb begin
      stall_rs     = 1'b0;
      stall_rt     = 1'b0;
      hit_rs_d     = 1'b0;
      hit_rt_d     = 1'b0;
      hit_rs_e     = 1'b0;
      hit_rt_e     = 1'b0;
      hit_rt_m     = 1'b0;
      HSB_o_FwdRsD = FWD_OWN;
      HSB_o_FwdRtD = FWD_OWN;
      HSB_o_FwdRsE = FWD_OWN;
      HSB_o_FwdRtE = FWD_OWN;
      HSB_o_FwdRtM = FWD_OWN;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (!hit_rs_d && slot_hit(slot_addr_q[k], HSB_i_RsD)) begin
            hit_rs_d = 1'b1;
            stall_rs = (HSB_i_TuseRs != TUSE_NEVER) && (slot_tnew_q[k] > HSB_i_TuseRs);
            if (slot_tnew_q[k] == '0) HSB_o_FwdRsD = FW'(k + 1);
         end
         if (!hit_rt_d && slot_hit(slot_addr_q[k], HSB_i_RtD)) begin
            hit_rt_d = 1'b1;
            stall_rt = (HSB_i_TuseRt != TUSE_NEVER) && (slot_tnew_q[k] > HSB_i_TuseRt);
            if (slot_tnew_q[k] == '0) HSB_o_FwdRtD = FW'(k + 1);
         end
         if (k >= 1 && !hit_rs_e && slot_hit(slot_addr_q[k], rs_e_q)) begin
            hit_rs_e = 1'b1;
            if (slot_tnew_q[k] == '0) HSB_o_FwdRsE = FW'(k + 1);
         end
         if (k >= 1 && !hit_rt_e && slot_hit(slot_addr_q[k], rt_e_q)) begin
            hit_rt_e = 1'b1;
            if (slot_tnew_q[k] == '0) HSB_o_FwdRtE = FW'(k + 1);
         end
         if (k >= 2 && !hit_rt_m && slot_hit(slot_addr_q[k], rt_m_q)) begin
            hit_rt_m = 1'b1;
            if (slot_tnew_q[k] == '0) HSB_o_FwdRtM = FW'(k + 1);
         end
      end
   end

   hsb_md_busy #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md_busy (
      .clk_i    (HSB_i_Clk),
      .rst_i    (HSB_i_Reset),
      .start_i  (md_start_e_q),
      .is_div_i (md_is_div_e_q),
      .busy_o   (md_busy)
   );

   // A start still sitting in E has not loaded the counter yet.
   assign stall_md     = HSB_i_MdUseD & (md_busy | md_start_e_q);
   assign stall        = stall_rs | stall_rt | stall_md;
   assign HSB_o_Stall  = stall;
   assign HSB_o_MdBusy = md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a timeline model of issued
// instructions checked every cycle, plus hand-computed literal expectations.
module tb_hazard_scoreboard;

   localparam int MAXC = 512;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] rs_d, rt_d, waddr_d;
   logic [3:0] tuse_rs, tuse_rt, tnew_d;
   logic       md_start, md_div, md_use;
   logic       stall, md_busy;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

   int checks = 0;
   int errors = 0;

   // Model: instruction that entered E in cycle i; in cycle c it sits in slot c-i.
   bit iss_valid [MAXC];
   int iss_dest  [MAXC];
   int iss_tnew  [MAXC];
   int iss_rs    [MAXC];
   int iss_rt    [MAXC];
   int cyc       = 0;
   int md_s      = -1000;
   int md_lat    = 0;
   bit m_stall   = 1'b0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .HSB_i_Clk       (clk),
      .HSB_i_Reset     (rst),
      .HSB_i_RsD       (rs_d),
      .HSB_i_RtD       (rt_d),
      .HSB_i_TuseRs    (tuse_rs),
      .HSB_i_TuseRt    (tuse_rt),
      .HSB_i_TnewD     (tnew_d),
      .HSB_i_RegWAddrD (waddr_d),
      .HSB_i_MdStartD  (md_start),
      .HSB_i_MdIsDivD  (md_div),
      .HSB_i_MdUseD    (md_use),
      .HSB_o_Stall     (stall),
      .HSB_o_FwdRsD    (fwd_rs_d),
      .HSB_o_FwdRtD    (fwd_rt_d),
      .HSB_o_FwdRsE    (fwd_rs_e),
      .HSB_o_FwdRtE    (fwd_rt_e),
      .HSB_o_FwdRtM    (fwd_rt_m),
      .HSB_o_MdBusy    (md_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nearest(input int c, input int op, input int lo);
      for (int k = lo; k < 3; k++) begin
         if (c - k >= 0 && iss_valid[c-k] && iss_dest[c-k] != 0 && iss_dest[c-k] == op)
            return k;
      end
      return -1;
   endfunction

   function automatic int rem_at(input int c, input int k);
      int r;
      r = iss_tnew[c-k] - 1 - k;
      return (r < 0) ? 0 : r;
   endfunction

   task automatic compare_cycle();
      int c, k, e_stall, e_frd, e_ftd, e_fre, e_fte, e_ftm, e_busy, d, op;
      c = cyc;
      e_stall = 0; e_frd = 0; e_ftd = 0; e_fre = 0; e_fte = 0; e_ftm = 0;
      k = nearest(c, int'(rs_d), 0);
      if (k >= 0) begin
         if (tuse_rs != 4'hF && rem_at(c, k) > int'(tuse_rs)) e_stall = 1;
         if (rem_at(c, k) == 0) e_frd = k + 1;
      end
      k = nearest(c, int'(rt_d), 0);
      if (k >= 0) begin
         if (tuse_rt != 4'hF && rem_at(c, k) > int'(tuse_rt)) e_stall = 1;
         if (rem_at(c, k) == 0) e_ftd = k + 1;
      end
      op = iss_valid[c] ? iss_rs[c] : 0;
      k = nearest(c, op, 1);
      if (k >= 0 && rem_at(c, k) == 0) e_fre = k + 1;
      op = iss_valid[c] ? iss_rt[c] : 0;
      k = nearest(c, op, 1);
      if (k >= 0 && rem_at(c, k) == 0) e_fte = k + 1;
      op = (c >= 1 && iss_valid[c-1]) ? iss_rt[c-1] : 0;
      k = nearest(c, op, 2);
      if (k >= 0 && rem_at(c, k) == 0) e_ftm = k + 1;
      d = c - md_s;
      e_busy = (d >= 1 && d <= md_lat) ? 1 : 0;
      if (md_use && (e_busy == 1 || d == 0)) e_stall = 1;
      m_stall = (e_stall != 0);
      check("cyc_stall", stall, e_stall);
      check("cyc_md_busy", md_busy, e_busy);
      check("cyc_fwd_rs_d", fwd_rs_d, e_frd);
      check("cyc_fwd_rt_d", fwd_rt_d, e_ftd);
      check("cyc_fwd_rs_e", fwd_rs_e, e_fre);
      check("cyc_fwd_rt_e", fwd_rt_e, e_fte);
      check("cyc_fwd_rt_m", fwd_rt_m, e_ftm);
   endtask

   initial forever begin
      @(negedge clk);
      compare_cycle();
   end

   // Model update: an unstalled D instruction enters E in the following cycle.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         for (int i = 0; i < MAXC; i++) iss_valid[i] = 1'b0;
         md_s    = -1000;
         m_stall = 1'b0;
      end else if (cyc + 1 < MAXC && !m_stall) begin
         iss_valid[cyc+1] = 1'b1;
         iss_dest[cyc+1]  = (tnew_d == 4'd0) ? 0 : int'(waddr_d);
         iss_tnew[cyc+1]  = int'(tnew_d);
         iss_rs[cyc+1]    = int'(rs_d);
         iss_rt[cyc+1]    = int'(rt_d);
         if (md_start) begin
            md_s   = cyc + 1;
            md_lat = md_div ? 10 : 5;
         end
      end
      cyc++;
   end

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [3:0] trs,
                        input logic [3:0] trt, input logic [3:0] tnew, input logic [4:0] wa,
                        input logic ms, input logic mdv, input logic mu);
      rs_d = rs; rt_d = rt; tuse_rs = trs; tuse_rt = trt; tnew_d = tnew; waddr_d = wa;
      md_start = ms; md_div = mdv; md_use = mu;
   endtask

   task automatic nop();
      drive(5'd0, 5'd0, 4'hF, 4'hF, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nop();
      #1 rst = 1'b1;
      #1;
      check("rst_stall", stall, 0);
      check("rst_busy", md_busy, 0);
      check("rst_fwd_rs_d", fwd_rs_d, 0);
      next(); next();
      rst = 1'b0;

      // addu $3 then beq $3,$3
      next(); drive(5'd1, 5'd2, 4'd1, 4'd1, 4'd2, 5'd3, 1'b0, 1'b0, 1'b0);
      #1 check("addu_stall", stall, 0);
      next(); drive(5'd3, 5'd3, 4'd0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 check("beq_stall", stall, 1);
      check("beq_fwd_wait", fwd_rs_d, 0);
      next(); #1 check("beq_release", stall, 0);
      check("beq_fwd_rs", fwd_rs_d, 2);
      check("beq_fwd_rt", fwd_rt_d, 2);

      // lw $5 then addu $6,$5,$5
      next(); drive(5'd29, 5'd0, 4'd1, 4'hF, 4'd3, 5'd5, 1'b0, 1'b0, 1'b0);
      #1 check("lw_stall", stall, 0);
      next(); drive(5'd5, 5'd5, 4'd1, 4'd1, 4'd2, 5'd6, 1'b0, 1'b0, 1'b0);
      #1 check("lwuse_stall", stall, 1);
      next(); #1 check("lwuse_release", stall, 0);
      check("lwuse_fwd_d", fwd_rs_d, 0);
      next(); nop();
      #1 check("lwuse_fwd_rs_e", fwd_rs_e, 3);
      check("lwuse_fwd_rt_e", fwd_rt_e, 3);

      // jal then jr $31
      next(); drive(5'd0, 5'd0, 4'hF, 4'hF, 4'd1, 5'd31, 1'b0, 1'b0, 1'b0);
      next(); drive(5'd31, 5'd0, 4'd0, 4'hF, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 check("jr_stall", stall, 0);
      check("jr_fwd", fwd_rs_d, 1);

      // ori $4, lw $4, sw $4: nearest producer shadows the older one
      next(); drive(5'd0, 5'd0, 4'd1, 4'hF, 4'd2, 5'd4, 1'b0, 1'b0, 1'b0);
      next(); drive(5'd29, 5'd0, 4'd1, 4'hF, 4'd3, 5'd4, 1'b0, 1'b0, 1'b0);
      next(); drive(5'd29, 5'd4, 4'd1, 4'd2, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 check("sw_stall", stall, 0);
      check("sw_fwd_rt_d", fwd_rt_d, 0);
      next(); nop();
      #1 check("sw_fwd_rt_e", fwd_rt_e, 0);
      next(); #1 check("sw_fwd_rt_m", fwd_rt_m, 3);

      // write to $0 never stalls or forwards
      next(); drive(5'd0, 5'd0, 4'hF, 4'hF, 4'd2, 5'd0, 1'b0, 1'b0, 1'b0);
      next(); drive(5'd0, 5'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 check("r0_stall", stall, 0);
      check("r0_fwd", fwd_rs_d, 0);

      // div then mflo
      next(); drive(5'd0, 5'd0, 4'hF, 4'hF, 4'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      #1 check("div_busy0", md_busy, 0);
      check("div_stall0", stall, 0);
      next(); drive(5'd0, 5'd0, 4'hF, 4'hF, 4'd2, 5'd8, 1'b0, 1'b0, 1'b1);
      #1 check("mflo_stall_e", stall, 1);
      check("mflo_busy_e", md_busy, 0);
      for (int n = 0; n < 10; n++) begin
         next(); #1 check("div_busy", md_busy, 1);
         check("div_mflo_stall", stall, 1);
      end
      next(); #1 check("div_busy_end", md_busy, 0);
      check("mflo_release", stall, 0);

      // mult then mfhi
      next(); drive(5'd0, 5'd0, 4'hF, 4'hF, 4'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      #1 check("mult_stall0", stall, 0);
      next(); drive(5'd0, 5'd0, 4'hF, 4'hF, 4'd2, 5'd9, 1'b0, 1'b0, 1'b1);
      #1 check("mfhi_stall_e", stall, 1);
      for (int n = 0; n < 5; n++) begin
         next(); #1 check("mult_busy", md_busy, 1);
      end
      next(); #1 check("mult_busy_end", md_busy, 0);
      check("mfhi_release", stall, 0);

      // reset mid-division with lw in E
      next(); drive(5'd0, 5'd0, 4'hF, 4'hF, 4'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      next(); drive(5'd29, 5'd0, 4'd1, 4'hF, 4'd3, 5'd7, 1'b0, 1'b0, 1'b0);
      #1 check("lw_div_stall", stall, 0);
      next(); drive(5'd7, 5'd0, 4'd0, 4'hF, 4'd2, 5'd9, 1'b0, 1'b0, 1'b1);
      #1 check("pre_rst_busy", md_busy, 1);
      check("pre_rst_stall", stall, 1);
      #1 rst = 1'b1;
      #1 check("arst_busy", md_busy, 0);
      check("arst_stall", stall, 0);
      check("arst_fwd_rs_d", fwd_rs_d, 0);
      check("arst_fwd_rt_d", fwd_rt_d, 0);
      check("arst_fwd_rs_e", fwd_rs_e, 0);
      check("arst_fwd_rt_e", fwd_rt_e, 0);
      check("arst_fwd_rt_m", fwd_rt_m, 0);
      next(); next();
      rst = 1'b0;
      nop();
      repeat (3) next();
      #1 check("post_rst_busy", md_busy, 0);
      check("post_rst_stall", stall, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Sequential hazard controller for the 5-stage MIPS pipeline; sits beside the D stage and consumes per-instruction Tuse/Tnew/destination from the hazard instruction decoder.
- Tracks a parametrised depth of in-flight producers with decrementing Tnew counters.
- Generates the D-stage stall plus forwarding selects for D, E and M consumers.
- Adds a multi-cycle HI/LO (mult/div) busy tracker, which the combinational decoder lacks.

Parameters:
- NUM_STAGES, 3, tracked producer slots after D (0=E, 1=M, 2=W).
- REG_AW, 5, register address width.
- T_W, 4, Tuse/Tnew width.
- MULT_LAT, 5, cycles HI/LO busy after mult enters E.
- DIV_LAT, 10, cycles HI/LO busy after div enters E.

Ports:
- HSB_i_Clk  in  1  clock, rising edge.
- HSB_i_Reset  in  1  reset, asynchronous, active-high.
- HSB_i_RsD, HSB_i_RtD  in  REG_AW  source registers of the D instruction.
- HSB_i_TuseRs, HSB_i_TuseRt  in  T_W  D-stage Tuse; T_USE_NEVER_READ means unused.
- HSB_i_TnewD  in  T_W  D-stage Tnew; T_NEW_NO_NEW means no write.
- HSB_i_RegWAddrD  in  REG_AW  destination of the D instruction.
- HSB_i_MdStartD  in  1  D instruction is mult/multu/div/divu.
- HSB_i_MdIsDivD  in  1  with MdStartD: div variant.
- HSB_i_MdUseD  in  1  D instruction touches HI/LO (mf*/mt*/mult/div).
- HSB_o_Stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX.
- HSB_o_FwdRsD, HSB_o_FwdRtD  out  FW  D-operand source.
- HSB_o_FwdRsE, HSB_o_FwdRtE  out  FW  E-operand source.
- HSB_o_FwdRtM  out  FW  M store-data source.
- HSB_o_MdBusy  out  1  HI/LO unit busy.
- FW = $clog2(NUM_STAGES+1). Codes: 0 = own pipeline/regfile, k = pipeline register after slot k-1 (1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB).

Behaviour:
- Slot k holds {addr, tnew}. Consumer registers RsE, RtE, RtM are shadowed alongside.
- Each rising edge, all slots shift k->k+1; the slot NUM_STAGES-1 entry is dropped.
- Slot 0 load when not stalled: addr = (TnewD==T_NEW_NO_NEW) ? 0 : RegWAddrD; tnew = sat0(TnewD-1).
- Slot 0 load when stalled: bubble, addr 0, tnew 0.
- Shifting entries get tnew = sat0(tnew-1).
- A result is forwardable from slot k when tnew==0.
- Match rule for a consumer: addr!=0 and addr==operand. Only the nearest (lowest k) matching slot counts; older matches are shadowed.
- D stall: per operand with Tuse!=NEVER, stall if nearest match has tnew > Tuse.
- D forward: code k+1 when nearest match has tnew==0, otherwise 0.
- E forward: RsE/RtE are matched against slots 1.., code k+1. M forward: RtM is matched against slots 2.., code k+1.
- Register 0 never stalls or forwards.
- MD tracker (counter width clog2(DIV_LAT+1)):
  - When a start instruction enters slot 0 unstalled, the next edge loads the counter with MULT_LAT or DIV_LAT; it then decrements to 0.
  - MdBusy = counter!=0.
  - Stall also when MdUseD and (MdBusy or an MD start sits in slot 0).
  - No new start can arrive while busy; D is stalled.
- HSB_o_Stall is the OR of all stall causes and is combinational from state and D inputs.
- Reset (async, at any time, including mid-division): all slots, consumer shadows and the MD counter clear to 0. MdBusy=0. All Fwd outputs are 0. Stall is 0 unless caused by D inputs alone, which cannot happen with empty slots.

Decomposition:
- Shared hazard definitions header:
  - T_USE_AT_D/E/M=0/1/2, T_USE_NEVER_READ=4'hF.
  - T_NEW_NO_NEW=0, T_NEW_AT_ID_EX/EX_MEM/MEM_WB=1/2/3.
  - FWD_SEL_* codes.
- One sub-module: hsb_md_busy (load/decrement counter, busy flag).

Test Plan:
- addu $3 (TnewD 2) then beq $3,$3 (Tuse 0) -> Stall=1 for 1 cycle; next cycle FwdRsD=FwdRtD=2, Stall=0.
- lw $5 (TnewD 3) then addu $6,$5,$5 (Tuse 1) -> Stall=1 for 1 cycle; addu in E then sees FwdRsE=FwdRtE=3.
- jal (TnewD 1, addr 31) then jr $31 (Tuse 0) -> no stall, FwdRsD=1.
- ori $4 and lw $4 in flight, sw $4 in D -> nearest producer wins; sw Rt forwarded in M via FwdRtM=3; write to $0 -> never stalls, Fwd 0.
- div, then mflo -> MdBusy high for exactly 10 cycles after div leaves E, mflo stalled throughout, released the cycle MdBusy falls; mult -> 5 cycles.
- Assert reset during MD busy with lw in slot 0 -> MdBusy=0, Stall=0, all Fwd=0 immediately, without waiting for a clock edge.
